// File: rtl/ram_loader_pkg.sv
// Shared definitions for the monitor-RAM loader: sizes and FSM state encoding.
package ram_loader_pkg;

  localparam int RAM_ADDR_W = 12;
  localparam int RAM_DATA_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    LD_HI,
    LD_LO,
    LD_WR,
    DP_RD,
    DP_WAIT,
    DP_HI,
    DP_LO,
    DONE
  } state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream and RAM-bus signals of the loader; master is the loader side.
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_W-1:0]     mem_address;
  logic [RAM_DATA_W-1:0] mem_dout;
  logic [RAM_DATA_W-1:0] mem_din;
  logic                  mem_rnw;
  logic                  mem_cs_b;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_din,
    output rx_ready, tx_data, tx_valid, mem_address, mem_dout, mem_rnw, mem_cs_b
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_din,
    input  rx_ready, tx_data, tx_valid, mem_address, mem_dout, mem_rnw, mem_cs_b
  );

endinterface

// File: rtl/ram_loader.sv
// Loads a big-endian byte stream into consecutive RAM words, or dumps RAM
// words back out as a byte stream. All outputs derive from registered state.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  ram_loader_if.master      bus,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t                state, state_n;
  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W-1:0]     last_addr;
  logic [ADDR_W:0]       remaining;
  logic [7:0]            hi, lo;
  logic [RAM_DATA_W-1:0] word;
  logic [RAM_DATA_W-1:0] last_dout;
  logic                  access;

  always_comb begin
    state_n = state;
    if (abort && state != IDLE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_load)      state_n = (word_count != '0) ? LD_HI : DONE;
          else if (start_dump) state_n = (word_count != '0) ? DP_RD : DONE;
        end
        LD_HI:   if (bus.rx_valid) state_n = LD_LO;
        LD_LO:   if (bus.rx_valid) state_n = LD_WR;
        LD_WR:   state_n = (remaining == CNT_ONE) ? DONE : LD_HI;
        DP_RD:   state_n = DP_WAIT;
        DP_WAIT: state_n = DP_HI;
        DP_HI:   if (bus.tx_ready) state_n = DP_LO;
        DP_LO:   if (bus.tx_ready) state_n = (remaining == CNT_ONE) ? DONE : DP_RD;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state     <= IDLE;
      addr      <= '0;
      last_addr <= '0;
      remaining <= '0;
      hi        <= '0;
      lo        <= '0;
      word      <= '0;
      last_dout <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start_load || start_dump) begin
            addr      <= base_addr;
            remaining <= word_count;
          end
        end
        LD_HI: if (bus.rx_valid) hi <= bus.rx_data;
        LD_LO: if (bus.rx_valid) lo <= bus.rx_data;
        LD_WR: begin
          last_addr <= addr;
          last_dout <= {hi, lo};
          addr      <= addr + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
        end
        DP_RD:   last_addr <= addr;
        DP_WAIT: word <= bus.mem_din;
        DP_LO: begin
          if (bus.tx_ready) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Address/data are muxed from registers so the bus holds its last value between accesses.
  assign access          = (state == LD_WR) || (state == DP_RD);
  assign bus.mem_cs_b    = !access;
  assign bus.mem_rnw     = (state != LD_WR);
  assign bus.mem_address = access ? addr : last_addr;
  assign bus.mem_dout    = (state == LD_WR) ? {hi, lo} : last_dout;
  assign bus.rx_ready    = (state == LD_HI) || (state == LD_LO);
  assign bus.tx_valid    = (state == DP_HI) || (state == DP_LO);
  assign bus.tx_data     = (state == DP_HI) ? word[15:8] :
                           (state == DP_LO) ? word[7:0]  : 8'h00;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_ram_loader.sv
// Directed and randomized bench for ram_loader against a 4K x 16 RAM model
// and a word-level reference memory image.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start_load, start_dump, abort;
  logic [11:0] base_addr;
  logic [12:0] word_count;
  logic        busy, done;

  ram_loader_if #(.ADDR_W(12)) bus_i ();

  ram_loader #(.ADDR_W(12)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .start_load (start_load),
    .start_dump (start_dump),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus_i),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 40503 + 7) ^ (i >> 3));
  endfunction

  // RAM model: synchronous write, one-cycle registered read
  logic [15:0] ram [4096];
  logic [15:0] rd_q = '0;
  assign bus_i.mem_din = rd_q;
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (!bus_i.mem_cs_b) begin
        if (!bus_i.mem_rnw) ram[bus_i.mem_address] <= bus_i.mem_dout;
        else                rd_q <= ram[bus_i.mem_address];
      end
    end
  end

  int n_wr = 0, n_rd = 0, n_done = 0, n_txv = 0;
  always @(negedge clk) begin
    if (!bus_i.mem_cs_b) begin
      if (bus_i.mem_rnw) n_rd++;
      else               n_wr++;
    end
    if (done) n_done++;
    if (bus_i.tx_valid) n_txv++;
  end

  int n_chk = 0, n_fail = 0;
  logic [15:0] ref_mem [4096];
  logic [7:0]  rx_q[$], tx_got[$], exp_q[$], ld_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit ld, input bit dp, input logic [11:0] b, input logic [12:0] c);
    base_addr = b; word_count = c; start_load = ld; start_dump = dp;
    step();
    start_load = 0; start_dump = 0;
  endtask

  // mode 0: always ready, 1: tx_ready toggles 1/0, 2: random valid/ready gaps
  task automatic run_until_idle(input int mode, input string tag);
    int  cyc = 0;
    bit  held = 0, tog = 1, hs;
    logic [7:0] held_d = '0;
    while (busy && cyc < 2000) begin
      case (mode)
        0: begin bus_i.tx_ready = 1; bus_i.rx_valid = (rx_q.size() > 0); end
        1: begin bus_i.tx_ready = tog; tog = !tog; bus_i.rx_valid = (rx_q.size() > 0); end
        default: begin
          bus_i.tx_ready = 1'($urandom_range(0, 1));
          bus_i.rx_valid = (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
        end
      endcase
      bus_i.rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      if (held) begin
        chk({tag, "_txv_hold"}, bus_i.tx_valid, 1);
        chk({tag, "_txd_hold"}, bus_i.tx_data, held_d);
      end
      held = 0;
      if (bus_i.tx_valid && bus_i.tx_ready) tx_got.push_back(bus_i.tx_data);
      else if (bus_i.tx_valid) begin held = 1; held_d = bus_i.tx_data; end
      hs = bus_i.rx_valid && bus_i.rx_ready;
      step();
      if (hs) void'(rx_q.pop_front());
      cyc++;
    end
    bus_i.rx_valid = 0; bus_i.tx_ready = 0;
    chk({tag, "_finished"}, cyc < 2000, 1);
  endtask

  task automatic do_load(input logic [11:0] b, input int cnt, input int mode, input string tag);
    logic [11:0] a;
    rx_q = ld_bytes;
    for (int i = 0; i < cnt; i++) begin
      a = b + 12'(i);
      ref_mem[a] = {ld_bytes[2*i], ld_bytes[2*i+1]};
    end
    start(1, 0, b, 13'(cnt));
    run_until_idle(mode, tag);
    chk({tag, "_rx_consumed"}, rx_q.size(), 0);
  endtask

  task automatic do_dump(input logic [11:0] b, input int cnt, input int mode, input string tag);
    logic [11:0] a;
    tx_got.delete(); exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      a = b + 12'(i);
      exp_q.push_back(ref_mem[a][15:8]);
      exp_q.push_back(ref_mem[a][7:0]);
    end
    start(0, 1, b, 13'(cnt));
    run_until_idle(mode, tag);
    chk({tag, "_len"}, tx_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), tx_got[i], exp_q[i]);
  endtask

  task automatic chk_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk(tag, mism, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int s_wr, s_rd, s_done, s_txv, cnt, b;

  initial begin
    reset_b = 0; start_load = 0; start_dump = 0; abort = 0;
    base_addr = '0; word_count = '0;
    bus_i.rx_data = '0; bus_i.rx_valid = 0; bus_i.tx_ready = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs_b", bus_i.mem_cs_b, 1);
    chk("rst_rnw", bus_i.mem_rnw, 1);
    chk("rst_addr", bus_i.mem_address, 0);
    chk("rst_dout", bus_i.mem_dout, 0);
    chk("rst_rx_ready", bus_i.rx_ready, 0);
    chk("rst_tx_valid", bus_i.tx_valid, 0);
    chk("rst_tx_data", bus_i.tx_data, 0);
    reset_b = 1;
    step();

    // basic load, rx_valid always high
    s_wr = n_wr; s_done = n_done;
    ld_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(12'h010, 2, 0, "load1");
    chk("load1_ram10", ram[12'h010], 16'h1234);
    chk("load1_ram11", ram[12'h011], 16'h5678);
    chk("load1_writes", n_wr - s_wr, 2);
    chk("load1_done", n_done - s_done, 1);
    chk("load1_busy", busy, 0);
    chk_mem("load1_image");

    // dump with tx_ready toggling
    s_rd = n_rd; s_wr = n_wr;
    do_dump(12'h010, 2, 1, "dump1");
    chk("dump1_reads", n_rd - s_rd, 2);
    chk("dump1_writes", n_wr - s_wr, 0);

    // address wrap
    s_wr = n_wr;
    ld_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(12'hFFF, 2, 0, "wrap");
    chk("wrap_ramfff", ram[12'hFFF], 16'hAABB);
    chk("wrap_ram000", ram[12'h000], 16'hCCDD);
    chk("wrap_writes", n_wr - s_wr, 2);
    chk_mem("wrap_image");

    // zero-count dump
    s_wr = n_wr; s_rd = n_rd; s_done = n_done; s_txv = n_txv;
    start(0, 1, 12'h123, 13'd0);
    chk("zero_busy_done", busy, 1);
    chk("zero_done_pulse", done, 1);
    step();
    chk("zero_idle", busy, 0);
    chk("zero_done_low", done, 0);
    chk("zero_access", (n_wr - s_wr) + (n_rd - s_rd), 0);
    chk("zero_txv", n_txv - s_txv, 0);
    chk("zero_done_cnt", n_done - s_done, 1);

    // both starts together: load wins; later dump start ignored
    s_rd = n_rd; s_txv = n_txv;
    ref_mem[12'h020] = 16'h9ABC;
    start(1, 1, 12'h020, 13'd1);
    chk("both_rx_ready", bus_i.rx_ready, 1);
    chk("both_tx_valid", bus_i.tx_valid, 0);
    start(0, 1, 12'h400, 13'd3);
    chk("both_still_load", bus_i.rx_ready, 1);
    rx_q = '{8'h9A, 8'hBC};
    run_until_idle(0, "both");
    chk("both_ram", ram[12'h020], 16'h9ABC);
    chk("both_no_reads", n_rd - s_rd, 0);
    chk("both_no_txv", n_txv - s_txv, 0);

    // abort during DP_HI
    s_done = n_done;
    bus_i.tx_ready = 0;
    start(0, 1, 12'h010, 13'd2);
    for (int i = 0; i < 10 && !bus_i.tx_valid; i++) step();
    chk("abort_hi_byte", bus_i.tx_data, 8'h12);
    abort = 1;
    step();
    abort = 0;
    chk("abort_idle", busy, 0);
    chk("abort_txv", bus_i.tx_valid, 0);
    s_wr = n_wr; s_rd = n_rd;
    repeat (5) step();
    chk("abort_no_access", (n_wr - s_wr) + (n_rd - s_rd), 0);
    chk("abort_no_done", n_done - s_done, 0);

    // reset during LD_LO
    s_done = n_done; s_wr = n_wr;
    start(1, 0, 12'h200, 13'd2);
    bus_i.rx_valid = 1; bus_i.rx_data = 8'hEE;
    step();
    bus_i.rx_valid = 0;
    chk("rstmid_in_lo", bus_i.rx_ready, 1);
    reset_b = 0;
    step();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rx_ready", bus_i.rx_ready, 0);
    chk("rstmid_cs_b", bus_i.mem_cs_b, 1);
    chk("rstmid_addr", bus_i.mem_address, 0);
    chk("rstmid_dout", bus_i.mem_dout, 0);
    reset_b = 1;
    repeat (4) step();
    chk("rstmid_no_write", n_wr - s_wr, 0);
    chk("rstmid_no_done", n_done - s_done, 0);
    chk_mem("rstmid_image");

    // randomized load/dump rounds with random handshake gaps
    for (int r = 0; r < 4; r++) begin
      b   = int'($urandom_range(0, 4095));
      cnt = int'($urandom_range(1, 6));
      ld_bytes.delete();
      for (int i = 0; i < 2 * cnt; i++) ld_bytes.push_back(8'($urandom));
      s_wr = n_wr;
      do_load(12'(b), cnt, 2, $sformatf("rload%0d", r));
      chk($sformatf("rload%0d_writes", r), n_wr - s_wr, cnt);
      chk_mem($sformatf("rload%0d_image", r));
      do_dump(12'(b), cnt, 2, $sformatf("rdump%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
